m_cp0: RTL and testbench

Coprocessor-0 for the P7 pipeline, sitting in the M stage directly downstream of the E-stage ALU. It consumes the pipelined exception code the ALU raises (AdEL/AdES/Ov), merges it with external hardware interrupts, and decides whether to redirect the pipeline to the handler. It holds SR, Cause and EPC, services `mtc0`/`mfc0` and `eret`, and drives the flush/redirect request back to the pipeline control.

---
 rtl/m_cp0.sv | 68 ++++++
 tb/tb_m_cp0.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/m_cp0.sv
// m_cp0: M-stage coprocessor 0 (SR/Cause/EPC, exceptions, interrupts, eret).
// Optional PRId register at address 15 is enabled by defining CP0_PRID_EN.
module m_cp0 #(
  parameter logic [31:0] PRID_VALUE = 32'h2025_0007
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] cp0_in,
  output logic [31:0] cp0_out,
  input  logic [31:0] vpc,
  input  logic        bd_in,
  input  logic [4:0]  exc_code_in,
  input  logic [5:0]  hw_int,
  input  logic        exl_clr,
  output logic [31:0] epc_out,
  output logic        req
);
`ifdef CP0_PRID_EN
  localparam logic PRID_EN = 1'b1;
`else
  localparam logic PRID_EN = 1'b0;
`endif
  logic [5:0]  im, ip;
  logic        exl, ie, bd;
  logic [4:0]  exc;
  logic [31:0] epc, sr_w, cause_w;
  logic        int_req, exc_req;
  assign int_req = |(hw_int & im) & ie & ~exl;
  assign exc_req = (exc_code_in != 5'd0) & ~exl;
  assign req     = int_req | exc_req;
  assign sr_w    = {16'h0, im, 8'h0, exl, ie};
  assign cause_w = {bd, 15'h0, ip, 3'h0, exc, 2'h0};
  assign epc_out = epc;
  always_comb
    cp0_out = cp0_addr == 5'd12 ? sr_w :
              cp0_addr == 5'd13 ? cause_w :
              cp0_addr == 5'd14 ? epc :
              cp0_addr == 5'd15 && PRID_EN ? PRID_VALUE : 32'h0;
  // req beats eret beats mtc0; a later eret clear overrides an mtc0 EXL write
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      im  <= '0;
      ip  <= '0;
      exl <= 1'b0;
      ie  <= 1'b0;
      bd  <= 1'b0;
      exc <= '0;
      epc <= '0;
    end else begin
      ip <= hw_int;
      if (req) begin
        exl <= 1'b1;
        exc <= int_req ? 5'd0 : exc_code_in;
        bd  <= bd_in;
        epc <= bd_in ? vpc - 32'd4 : vpc;
      end else begin
        if (en && cp0_addr == 5'd12) begin
          im  <= cp0_in[15:10];
          exl <= cp0_in[1];
          ie  <= cp0_in[0];
        end
        if (en && cp0_addr == 5'd14) epc <= cp0_in;
        if (exl_clr) exl <= 1'b0;
      end
    end
endmodule

// File: tb/tb_m_cp0.sv
// tb_m_cp0: directed bench for m_cp0 with a word-level reference model.
module tb_m_cp0;
  localparam logic [31:0] PRID = 32'h2025_0007;
  logic        clk = 1'b0, reset = 1'b0, en = 1'b0, bd_in = 1'b0, exl_clr = 1'b0;
  logic [4:0]  cp0_addr = 5'd0, exc_code_in = 5'd0;
  logic [31:0] cp0_in = 32'h0, vpc = 32'h0, cp0_out, epc_out;
  logic [5:0]  hw_int = 6'h0;
  logic        req;
  int checks = 0, errors = 0;
  logic [31:0] m_sr = 0, m_cause = 0, m_epc = 0;

  m_cp0 #(.PRID_VALUE(PRID)) dut (
    .clk(clk), .reset(reset), .en(en), .cp0_addr(cp0_addr), .cp0_in(cp0_in),
    .cp0_out(cp0_out), .vpc(vpc), .bd_in(bd_in), .exc_code_in(exc_code_in),
    .hw_int(hw_int), .exl_clr(exl_clr), .epc_out(epc_out), .req(req)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic m_int();
    return ((hw_int & m_sr[15:10]) != 6'h0) && m_sr[0] && !m_sr[1];
  endfunction

  function automatic logic m_req();
    return m_int() || (exc_code_in != 5'd0 && !m_sr[1]);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd12: return m_sr;
      5'd13: return m_cause;
      5'd14: return m_epc;
`ifdef CP0_PRID_EN
      5'd15: return PRID;
`endif
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk or negedge reset) begin
    logic [31:0] nsr, nca, nep;
    if (!reset) begin
      m_sr = 0; m_cause = 0; m_epc = 0;
    end else begin
      nsr = m_sr; nca = m_cause; nep = m_epc;
      nca[15:10] = hw_int;
      if (m_req()) begin
        nsr[1] = 1'b1;
        nca[6:2] = m_int() ? 5'd0 : exc_code_in;
        nca[31] = bd_in;
        nep = bd_in ? vpc - 32'd4 : vpc;
      end else begin
        if (en && cp0_addr == 5'd12) nsr = cp0_in & 32'h0000_FC03;
        if (en && cp0_addr == 5'd14) nep = cp0_in;
        if (exl_clr) nsr[1] = 1'b0;
      end
      m_sr = nsr; m_cause = nca; m_epc = nep;
    end
  end

  always @(negedge clk) begin
    chk("model_req", {31'h0, req}, {31'h0, m_req()});
    chk("model_cp0_out", cp0_out, m_read(cp0_addr));
    chk("model_epc_out", epc_out, m_epc);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    en = 0; exl_clr = 0; exc_code_in = 0; bd_in = 0; hw_int = 0;
  endtask

  task automatic rd(input logic [4:0] a, input string name, input logic [31:0] exp);
    cp0_addr = a;
    #1;
    chk(name, cp0_out, exp);
  endtask

  initial begin
    hw_int = 6'h3F;
    repeat (3) cyc();
    rd(12, "rst_sr", 32'h0);
    rd(13, "rst_cause", 32'h0);
    chk("rst_epc", epc_out, 32'h0);
    chk("rst_req", {31'h0, req}, 32'h0);
    cyc(); reset = 1;
    #1;
    rd(13, "rel_cause", 32'h0);
    chk("rel_req", {31'h0, req}, 32'h0);
    cyc(); idle(); cyc();
    // overflow exception
    exc_code_in = 12; vpc = 32'h3010; bd_in = 0;
    #1; chk("ov_req", {31'h0, req}, 32'h1);
    cyc(); idle();
    rd(14, "ov_epc", 32'h3010);
    chk("ov_epc_out", epc_out, 32'h3010);
    rd(13, "ov_cause", 32'h30);
    rd(12, "ov_sr", 32'h2);
    exc_code_in = 4;
    #1; chk("exl_masks_req", {31'h0, req}, 32'h0);
    cyc(); idle(); exl_clr = 1;
    cyc(); idle();
    rd(12, "eret_sr", 32'h0);
    // delay-slot store fault
    exc_code_in = 5; bd_in = 1; vpc = 32'h3024;
    cyc(); idle();
    rd(14, "bd_epc", 32'h3020);
    rd(13, "bd_cause", 32'h8000_0014);
    exl_clr = 1;
    cyc(); idle();
    // interrupt enable and priority over Ov
    en = 1; cp0_addr = 12; cp0_in = 32'h0000_0401;
    cyc(); idle();
    rd(12, "ie_sr", 32'h401);
    hw_int = 6'b000001; exc_code_in = 12; vpc = 32'h3100;
    #1; chk("int_req", {31'h0, req}, 32'h1);
    cyc(); exc_code_in = 0;
    rd(13, "int_cause", 32'h400);
    rd(12, "int_sr", 32'h403);
    // eret + mtc0 EPC while EXL=1
    exl_clr = 1; en = 1; cp0_addr = 14; cp0_in = 32'hDEAD;
    #1; chk("eret_no_req", {31'h0, req}, 32'h0);
    cyc(); idle();
    rd(12, "eret_mtc_sr", 32'h401);
    chk("eret_mtc_epc", epc_out, 32'hDEAD);
    // eret loses to a pending interrupt
    exl_clr = 1; hw_int = 6'b000001; vpc = 32'h3200;
    #1; chk("eret_int_req", {31'h0, req}, 32'h1);
    cyc(); idle();
    rd(12, "eret_int_sr", 32'h403);
    chk("eret_int_epc", epc_out, 32'h3200);
    // eret together with mtc0 SR: EXL from eret, rest from data
    exl_clr = 1; en = 1; cp0_addr = 12; cp0_in = 32'hFFFF_0802;
    cyc(); idle();
    rd(12, "eret_sr_write", 32'h800);
    rd(13, "cause_before", 32'h0);
    en = 1; cp0_addr = 13; cp0_in = 32'hFFFF_FFFF;
    cyc(); idle();
    rd(13, "cause_ro", 32'h0);
    en = 1; cp0_addr = 15; cp0_in = 32'h1234_5678;
    cyc(); idle();
`ifdef CP0_PRID_EN
    rd(15, "prid", PRID);
`else
    rd(15, "prid_off", 32'h0);
`endif
    rd(7, "unimpl", 32'h0);
    // mtc0 dropped by syscall exception
    en = 1; cp0_addr = 14; cp0_in = 32'h1234; exc_code_in = 8; vpc = 32'h3300;
    cyc(); idle();
    chk("mtc0_dropped", epc_out, 32'h3300);
    exl_clr = 1;
    cyc(); idle();
    // modulo vpc-4 with misaligned pc
    exc_code_in = 10; bd_in = 1; vpc = 32'h2;
    cyc(); idle();
    chk("epc_wrap", epc_out, 32'hFFFF_FFFE);
    cp0_addr = 12;
    #1; reset = 0;
    #1; chk("async_rst_sr", cp0_out, 32'h0);
    chk("async_rst_epc", epc_out, 32'h0);
    cyc(); reset = 1;
    cyc(); cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
